// File: rtl/uart_dbg_wb_master.sv
// Debug-host command engine: parses UART byte commands into Wishbone master
// read/write cycles and streams read data back to the UART transmitter.
module uart_dbg_wb_master #(
  parameter int unsigned BYTE_TIMEOUT = 1000000,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam int unsigned BTO_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned ATO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SIZE, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_TX
  } state_t;

  state_t state, state_next;

  logic             is_write;
  logic [7:0]       word_cnt;
  logic [1:0]       byte_idx;
  logic [31:0]      addr;
  logic [31:0]      wdat;
  logic [31:0]      rdat;
  logic             cyc;
  logic             we;
  logic [ATO_W-1:0] ack_cnt;
  logic [BTO_W-1:0] bto_cnt;
  logic             skid_full;
  logic [7:0]       skid;

  logic       timed;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       byte_to;
  logic       ack_to;
  logic       cyc_end;

  // In WDATA a held skid byte takes priority over the live rx byte.
  assign timed    = (state == S_SIZE) || (state == S_ADDR) || (state == S_WDATA);
  assign in_valid = (state == S_WDATA) ? (skid_full || rx_valid) : rx_valid;
  assign in_byte  = (state == S_WDATA && skid_full) ? skid : rx_data;
  assign byte_to  = timed && !in_valid && (bto_cnt == BTO_W'(BYTE_TIMEOUT - 1));
  assign ack_to   = cyc && !wbm_ack_i && (ack_cnt == ATO_W'(ACK_TIMEOUT - 1));
  assign cyc_end  = cyc && (wbm_ack_i || ack_to);

  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign wbm_we_o  = we;
  assign wbm_sel_o = cyc ? 4'hF : 4'h0;
  assign wbm_adr_o = addr;
  assign wbm_dat_o = wdat;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    tx_valid   = (state == S_TX);
    case (byte_idx)
      2'd0:    tx_data = rdat[31:24];
      2'd1:    tx_data = rdat[23:16];
      2'd2:    tx_data = rdat[15:8];
      default: tx_data = rdat[7:0];
    endcase
    case (state)
      S_IDLE:
        if (rx_valid && (rx_data == 8'h01 || rx_data == 8'h02)) state_next = S_SIZE;
      S_SIZE:
        if (byte_to) state_next = S_IDLE;
        else if (rx_valid) state_next = (rx_data == 8'h00) ? S_IDLE : S_ADDR;
      S_ADDR:
        if (byte_to) state_next = S_IDLE;
        else if (rx_valid && byte_idx == 2'd3) state_next = is_write ? S_WDATA : S_WB_RD;
      S_WDATA:
        if (byte_to) state_next = S_IDLE;
        else if (in_valid && byte_idx == 2'd3) state_next = S_WB_WR;
      S_WB_WR:
        if (cyc_end) state_next = (word_cnt == 8'd1) ? S_IDLE : S_WDATA;
      S_WB_RD:
        if (cyc_end) state_next = S_TX;
      S_TX:
        if (tx_ready && byte_idx == 2'd3) state_next = (word_cnt == 8'd0) ? S_IDLE : S_WB_RD;
      default:
        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      is_write  <= 1'b0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      addr      <= '0;
      wdat      <= '0;
      rdat      <= '0;
      cyc       <= 1'b0;
      we        <= 1'b0;
      ack_cnt   <= '0;
      bto_cnt   <= '0;
      skid_full <= 1'b0;
      skid      <= '0;
    end else begin
      if (!timed || in_valid || rx_valid || byte_to) bto_cnt <= '0;
      else                                           bto_cnt <= bto_cnt + 1'b1;

      if (cyc && !wbm_ack_i && !ack_to) ack_cnt <= ack_cnt + 1'b1;
      else                              ack_cnt <= '0;

      // A skid byte consumed in WDATA is immediately replaced by a same-cycle rx byte.
      case (state)
        S_WB_WR: if (rx_valid && !skid_full) begin
          skid      <= rx_data;
          skid_full <= 1'b1;
        end
        S_WDATA: begin
          skid_full <= skid_full && rx_valid;
          if (skid_full && rx_valid) skid <= rx_data;
        end
        default: skid_full <= 1'b0;
      endcase

      case (state)
        S_IDLE: if (rx_valid) begin
          is_write <= (rx_data == 8'h01);
          byte_idx <= '0;
        end
        S_SIZE: if (rx_valid) begin
          word_cnt <= rx_data;
          byte_idx <= '0;
        end
        S_ADDR: if (rx_valid) begin
          addr     <= {addr[23:0], rx_data};
          byte_idx <= byte_idx + 2'd1;
        end
        S_WDATA: if (in_valid) begin
          wdat     <= {wdat[23:0], in_byte};
          byte_idx <= byte_idx + 2'd1;
        end
        S_WB_WR, S_WB_RD: begin
          if (!cyc) begin
            cyc <= 1'b1;
            we  <= (state == S_WB_WR);
          end else if (cyc_end) begin
            cyc      <= 1'b0;
            we       <= 1'b0;
            addr     <= addr + 32'd4;
            word_cnt <= word_cnt - 8'd1;
            byte_idx <= '0;
            if (state == S_WB_RD) rdat <= wbm_ack_i ? wbm_dat_i : 32'hFFFF_FFFF;
          end
        end
        S_TX: if (tx_ready) byte_idx <= byte_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_wb_master.sv
// Directed bench for uart_dbg_wb_master: byte-level host commands against a
// small Wishbone slave and a UART TX sink.
module tb_uart_dbg_wb_master;

  localparam int unsigned BTO = 200;
  localparam int unsigned ATO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  logic        ack_en = 1'b1;
  logic [31:0] rd_q[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  uart_dbg_wb_master #(.BYTE_TIMEOUT(BTO), .ACK_TIMEOUT(ATO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
  );

  // Slave: acks one clock after seeing a strobe; read data comes from rd_q.
  always @(posedge clk) begin
    wbm_ack_i <= 1'b0;
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_en) begin
      wbm_ack_i <= 1'b1;
      log_adr.push_back(wbm_adr_o);
      log_dat.push_back(wbm_dat_o);
      log_we.push_back(wbm_we_o);
      log_sel.push_back(wbm_sel_o);
      if (!wbm_we_o) wbm_dat_i <= (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEADBEEF;
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic send_frame(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = v[8*(n-1-i) +: 8];
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b after %0d clocks, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, tx_valid, tx_data, busy} !== '0) begin
      errors++;
      $display("FAIL reset outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h txv=%b txd=%h busy=%b, required all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, tx_valid, tx_data, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    int b;
    b = log_adr.size();
    send_frame(128'h01_01_00_00_01_10_77_55_55_AB, 10);
    vectors++;
    if (wbm_stb_o !== 1'b0) begin
      errors++; $display("FAIL write latency1: stb=%b, required 0", wbm_stb_o);
    end
    @(posedge clk); #1;
    vectors++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'b1111111) begin
      errors++; $display("FAIL write latency2: cyc/stb/we/sel=%b, required 1111111",
                         {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
    end
    wait_idle(50, "write");
    vectors++;
    if (log_adr.size() != b + 1) begin
      errors++; $display("FAIL write count: %0d cycles, required 1", log_adr.size() - b);
    end else if ({log_adr[b], log_dat[b], log_we[b], log_sel[b]} !== {32'h110, 32'h775555AB, 1'b1, 4'hF}) begin
      errors++; $display("FAIL write cycle: adr=%h dat=%h we=%b sel=%h, required 110 775555ab 1 f",
                         log_adr[b], log_dat[b], log_we[b], log_sel[b]);
    end
  endtask

  task automatic test_read();
    int b, t, n;
    b = log_adr.size();
    t = tx_q.size();
    rd_q.push_back(32'h775555AB);
    send_frame(128'h02_01_00_00_01_10, 6);
    n = 0;
    while (wbm_ack_i !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL read pre-ack tx_valid=%b, required 0", tx_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h77}) begin
      errors++; $display("FAIL read ack-to-tx: tx_valid=%b tx_data=%h, required 1 77", tx_valid, tx_data);
    end
    wait_idle(50, "read");
    vectors++;
    if (tx_q.size() != t + 4) begin
      errors++; $display("FAIL read tx count: %0d bytes, required 4", tx_q.size() - t);
    end else if ({tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3]} !== 32'h775555AB) begin
      errors++; $display("FAIL read tx bytes: %h %h %h %h, required 77 55 55 ab",
                         tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3]);
    end
    vectors++;
    if (log_adr.size() != b + 1 || log_adr[b] !== 32'h110 || log_we[b] !== 1'b0) begin
      errors++; $display("FAIL read cycle: count=%0d, required 1 read at 110", log_adr.size() - b);
    end
  endtask

  task automatic test_back_to_back();
    int b, t;
    b = log_adr.size();
    t = tx_q.size();
    rd_q.push_back(32'h11223344);
    rd_q.push_back(32'hCAFEF00D);
    tx_ready = 1'b0;
    send_frame(128'h02_02_00_00_01_FC, 6);
    repeat (50) @(posedge clk);
    #1;
    vectors++;
    if (tx_q.size() != t || {tx_valid, tx_data, wbm_cyc_o, busy} !== {1'b1, 8'h11, 1'b0, 1'b1}) begin
      errors++; $display("FAIL stall: sent=%0d txv=%b txd=%h cyc=%b busy=%b, required 0 1 11 0 1",
                         tx_q.size() - t, tx_valid, tx_data, wbm_cyc_o, busy);
    end
    tx_ready = 1'b1;
    wait_idle(100, "b2b");
    vectors++;
    if (tx_q.size() != t + 8) begin
      errors++; $display("FAIL b2b tx count: %0d bytes, required 8", tx_q.size() - t);
    end else if ({tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3], tx_q[t+4], tx_q[t+5], tx_q[t+6], tx_q[t+7]}
                 !== 64'h11223344CAFEF00D) begin
      errors++; $display("FAIL b2b tx bytes: %h%h%h%h%h%h%h%h, required 11223344cafef00d",
                         tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3], tx_q[t+4], tx_q[t+5], tx_q[t+6], tx_q[t+7]);
    end
    vectors++;
    if (log_adr.size() != b + 2) begin
      errors++; $display("FAIL b2b cycles: %0d, required 2", log_adr.size() - b);
    end else if ({log_adr[b], log_adr[b+1]} !== {32'h1FC, 32'h200}) begin
      errors++; $display("FAIL b2b addr: %h %h, required 1fc 200", log_adr[b], log_adr[b+1]);
    end
  endtask

  task automatic test_ignore_and_size0();
    int b;
    b = log_adr.size();
    send_frame(128'h7E_01_01_00_00_00_20_DE_AD_BE_EF, 11);
    wait_idle(50, "ignore");
    vectors++;
    if (log_adr.size() != b + 1) begin
      errors++; $display("FAIL ignore count: %0d cycles, required 1", log_adr.size() - b);
    end else if ({log_adr[b], log_dat[b], log_we[b]} !== {32'h20, 32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL ignore cycle: adr=%h dat=%h we=%b, required 20 deadbeef 1",
                         log_adr[b], log_dat[b], log_we[b]);
    end
    send_frame(128'h02_00, 2);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (log_adr.size() != b + 1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL size0: extra cycles=%0d busy=%b txv=%b, required 0 0 0",
                         log_adr.size() - b - 1, busy, tx_valid);
    end
  endtask

  // Bytes back-to-back: 0x55 lands in the skid, 0x66/0x77 are dropped, 0xBB is discarded at IDLE.
  task automatic test_skid_wrap();
    int b;
    b = log_adr.size();
    send_frame(128'h01_02_FF_FF_FF_FC_11_22_33_44_55_66_77_88_99_AA, 16);
    send_frame(128'hBB, 1);
    wait_idle(50, "skid");
    vectors++;
    if (log_adr.size() != b + 2) begin
      errors++; $display("FAIL skid count: %0d cycles, required 2", log_adr.size() - b);
    end else if ({log_adr[b], log_dat[b], log_adr[b+1], log_dat[b+1]}
                 !== {32'hFFFFFFFC, 32'h11223344, 32'h00000000, 32'h558899AA}) begin
      errors++; $display("FAIL skid cycles: %h:%h %h:%h, required fffffffc:11223344 00000000:558899aa",
                         log_adr[b], log_dat[b], log_adr[b+1], log_dat[b+1]);
    end
  endtask

  task automatic test_ack_timeout();
    int t, n, hi;
    t = tx_q.size();
    ack_en = 1'b0;
    send_frame(128'h02_01_00_00_00_40, 6);
    n = 0;
    hi = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (wbm_cyc_o) hi++;
      else if (hi > 0) break;
    end
    vectors++;
    if (hi != ATO) begin
      errors++; $display("FAIL ack timeout length: cyc high %0d clocks, required %0d", hi, ATO);
    end
    wait_idle(50, "acktimeout");
    vectors++;
    if (tx_q.size() != t + 4) begin
      errors++; $display("FAIL ack timeout tx count: %0d, required 4", tx_q.size() - t);
    end else if ({tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3]} !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL ack timeout data: %h%h%h%h, required ffffffff",
                         tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3]);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_byte_timeout();
    int b, t;
    send_frame(128'h01_01_00, 3);
    repeat (190) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL byte timeout early: busy=%b, required 1", busy);
    end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL byte timeout: busy=%b, required 0", busy);
    end
    b = log_adr.size();
    t = tx_q.size();
    rd_q.push_back(32'h0BADF00D);
    send_frame(128'h02_01_00_00_00_80, 6);
    wait_idle(50, "post-timeout");
    vectors++;
    if (log_adr.size() != b + 1 || log_adr[b] !== 32'h80 || log_we[b] !== 1'b0 || tx_q.size() != t + 4) begin
      errors++; $display("FAIL post-timeout read: cycles=%0d tx=%0d, required 1 read at 80 and 4 bytes",
                         log_adr.size() - b, tx_q.size() - t);
    end else if ({tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3]} !== 32'h0BADF00D) begin
      errors++; $display("FAIL post-timeout data: %h%h%h%h, required 0badf00d",
                         tx_q[t], tx_q[t+1], tx_q[t+2], tx_q[t+3]);
    end
  endtask

  task automatic test_reset_mid_cycle();
    int n;
    ack_en = 1'b0;
    send_frame(128'h01_01_00_00_01_10_77_55_55_AB, 10);
    n = 0;
    while (!wbm_cyc_o && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (wbm_cyc_o !== 1'b1) begin
      errors++; $display("FAIL mid-reset setup: cyc=%b, required 1", wbm_cyc_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, tx_valid, tx_data, busy} !== '0) begin
      errors++;
      $display("FAIL mid-reset outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h txv=%b busy=%b, required all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, tx_valid, busy);
    end
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if ({wbm_cyc_o, busy} !== 2'b00) begin
      errors++; $display("FAIL post-reset idle: cyc=%b busy=%b, required 0 0", wbm_cyc_o, busy);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignore_and_size0();
    test_skid_wrap();
    test_ack_timeout();
    test_byte_timeout();
    test_reset_mid_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
